// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO port responder: register offsets, bit indices, default window.
// The timer block is built only when MMIO_TIMER_EN is defined.
package mmio_pkg;

  typedef logic [4:0] mmio_off_t;

  localparam logic [31:0] MMIO_BASE_ADDR = 32'hFFFF_0000;

  localparam mmio_off_t MMIO_OFF_PORT_OUT  = 5'h00;
  localparam mmio_off_t MMIO_OFF_PORT_IN   = 5'h04;
  localparam mmio_off_t MMIO_OFF_STATUS    = 5'h08;
  localparam mmio_off_t MMIO_OFF_TMR_COUNT = 5'h0C;
  localparam mmio_off_t MMIO_OFF_TMR_CMP   = 5'h10;
  localparam mmio_off_t MMIO_OFF_CTRL      = 5'h14;

  localparam int STAT_IN_CHG       = 0;
  localparam int STAT_TMR_EXP      = 1;
  localparam int CTRL_TMR_EN       = 0;
  localparam int CTRL_AUTO_RELOAD  = 1;
  localparam int CTRL_IN_CHG_MASK  = 2;
  localparam int CTRL_TMR_EXP_MASK = 3;

  // Word-aligned register offset of a byte address; low two bits are don't-care.
  function automatic mmio_off_t mmio_offset(input logic [31:0] addr);
    return {addr[4:2], 2'b00};
  endfunction

endpackage

// File: rtl/input_synchronizer.sv
// Two-flop synchronizer plus a history flop; changed flags a new synchronized value.
// Reusable for any asynchronous input bus.
module input_synchronizer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             changed
);

  logic [WIDTH-1:0] s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q       = s2;
  assign changed = (s2 != s3);

endmodule

// File: rtl/mmio_port_responder.sv
// MMIO responder: output port, synchronized input port with change flag, optional compare timer.
// Define MMIO_TIMER_EN to build the timer (TMR_COUNT, TMR_CMP, TMR_EXP and their CTRL bits).
module mmio_port_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = MMIO_BASE_ADDR,
  parameter int          IN_WIDTH  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  input  logic                MemWrite,
  input  logic                MemRead,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         ReadData,
  output logic                Hit,
  output logic [31:0]         PortOut,
  output logic                Irq
);

  mmio_off_t off;
  logic      wr, wr_out, wr_status, wr_ctrl;
  logic      unused_addr_lsb;

  assign Hit = (Address[31:5] == BASE_ADDR[31:5]);
  assign off = mmio_offset(Address);
  assign unused_addr_lsb = ^Address[1:0];

  assign wr        = MemWrite & Hit;
  assign wr_out    = wr && (off == MMIO_OFF_PORT_OUT);
  assign wr_status = wr && (off == MMIO_OFF_STATUS);
  assign wr_ctrl   = wr && (off == MMIO_OFF_CTRL);

  // Input port
  logic [IN_WIDTH-1:0] in_sync;
  logic                in_changed;
  logic [31:0]         port_in_ext;

  input_synchronizer #(.WIDTH(IN_WIDTH)) u_in_sync (
    .clk     (clk),
    .rst_n   (reset),
    .d       (PortIn),
    .q       (in_sync),
    .changed (in_changed)
  );

  always_comb begin
    port_in_ext = '0;
    port_in_ext[IN_WIDTH-1:0] = in_sync;
  end

  // Output port, change flag and its mask
  logic in_chg, in_chg_mask;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PortOut     <= '0;
      in_chg      <= 1'b0;
      in_chg_mask <= 1'b0;
    end else begin
      if (wr_out)  PortOut     <= WriteData;
      if (wr_ctrl) in_chg_mask <= WriteData[CTRL_IN_CHG_MASK];
      // a new change event beats a same-cycle W1C
      in_chg <= in_changed | (in_chg & ~(wr_status & WriteData[STAT_IN_CHG]));
    end
  end

  // Timer
  logic tmr_en, auto_reload, tmr_exp_mask, tmr_exp;

`ifdef MMIO_TIMER_EN
  logic [31:0] tmr_count, tmr_cmp;
  logic        wr_cmp, match;

  assign wr_cmp = wr && (off == MMIO_OFF_TMR_CMP);
  assign match  = tmr_en && (tmr_count == tmr_cmp);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr_count    <= '0;
      tmr_cmp      <= '0;
      tmr_en       <= 1'b0;
      auto_reload  <= 1'b0;
      tmr_exp_mask <= 1'b0;
      tmr_exp      <= 1'b0;
    end else begin
      if (wr_cmp) tmr_cmp <= WriteData;
      // a CTRL write overrides whatever the compare logic would do this cycle
      if (wr_ctrl) begin
        tmr_count    <= '0;
        tmr_en       <= WriteData[CTRL_TMR_EN];
        auto_reload  <= WriteData[CTRL_AUTO_RELOAD];
        tmr_exp_mask <= WriteData[CTRL_TMR_EXP_MASK];
      end else if (match) begin
        if (auto_reload) tmr_count <= '0;
        else             tmr_en    <= 1'b0;
      end else if (tmr_en) begin
        tmr_count <= tmr_count + 32'd1;
      end
      tmr_exp <= match | (tmr_exp & ~(wr_status & WriteData[STAT_TMR_EXP]));
    end
  end
`else
  assign tmr_en       = 1'b0;
  assign auto_reload  = 1'b0;
  assign tmr_exp_mask = 1'b0;
  assign tmr_exp      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) Irq <= 1'b0;
    else        Irq <= (in_chg & in_chg_mask) | (tmr_exp & tmr_exp_mask);
  end

  // Read mux shows pre-write state, so a simultaneous store is invisible this cycle
  always_comb begin
    ReadData = '0;
    if (MemRead && Hit) begin
      case (off)
        MMIO_OFF_PORT_OUT:  ReadData = PortOut;
        MMIO_OFF_PORT_IN:   ReadData = port_in_ext;
        MMIO_OFF_STATUS:    ReadData = {30'd0, tmr_exp, in_chg};
`ifdef MMIO_TIMER_EN
        MMIO_OFF_TMR_COUNT: ReadData = tmr_count;
        MMIO_OFF_TMR_CMP:   ReadData = tmr_cmp;
`endif
        MMIO_OFF_CTRL:      ReadData = {28'd0, tmr_exp_mask, in_chg_mask, auto_reload, tmr_en};
        default:            ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed bench for mmio_port_responder; covers the timer when MMIO_TIMER_EN is defined.
module tb_mmio_port_responder;

  localparam logic [31:0] B = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address, WriteData, ReadData, PortOut;
  logic        MemWrite, MemRead, Hit, Irq;
  logic [7:0]  PortIn;

  int n_chk  = 0;
  int n_pass = 0;

  mmio_port_responder dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .PortIn    (PortIn),
    .ReadData  (ReadData),
    .Hit       (Hit),
    .PortOut   (PortOut),
    .Irq       (Irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else             n_pass++;
  endtask

  // The bench lives just after a rising edge; tick advances exactly one edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address = a; WriteData = d; MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0;
  endtask

  task automatic rchk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    Address = a; MemRead = 1'b1;
    #1;
    chk(tag, ReadData, exp);
    MemRead = 1'b0;
  endtask

  initial begin
    reset = 1'b0; Address = '0; WriteData = '0; MemWrite = 1'b0; MemRead = 1'b0; PortIn = 8'h00;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("rst_portout", PortOut, 32'h0);
    chk("rst_irq", {31'd0, Irq}, 32'h0);
    rchk("rst_status", B + 32'h08, 32'h0);

    // output port
    wr(B, 32'hDEAD_BEEF);
    chk("portout_st", PortOut, 32'hDEAD_BEEF);
    rchk("portout_ld", B, 32'hDEAD_BEEF);
    rchk("lsb_ignored", B + 32'h3, 32'hDEAD_BEEF);
    Address = B + 32'h40; #1;
    chk("miss_hit", {31'd0, Hit}, 32'h0);
    wr(B + 32'h40, 32'h1234_5678);
    chk("miss_nochg", PortOut, 32'hDEAD_BEEF);
    Address = B + 32'h1C; #1;
    chk("top_hit", {31'd0, Hit}, 32'h1);
    wr(B + 32'h18, 32'hFFFF_FFFF);
    rchk("off18_zero", B + 32'h18, 32'h0);
    Address = B; MemRead = 1'b0; #1;
    chk("noread_zero", ReadData, 32'h0);

    // load+store together: load sees pre-write value
    Address = B; WriteData = 32'h0000_1111; MemWrite = 1'b1; MemRead = 1'b1; #1;
    chk("rw_prewrite", ReadData, 32'hDEAD_BEEF);
    tick();
    MemWrite = 1'b0; MemRead = 1'b0;
    chk("rw_postwrite", PortOut, 32'h0000_1111);

    // input path latency
    PortIn = 8'hA5;
    tick();
    rchk("pin_n", B + 32'h04, 32'h0);
    tick();
    rchk("pin_n1", B + 32'h04, 32'hA5);
    rchk("stat_n1", B + 32'h08, 32'h0);
    tick();
    rchk("stat_n2", B + 32'h08, 32'h1);
    wr(B + 32'h14, 32'h4);
    chk("irq_mask_edge", {31'd0, Irq}, 32'h0);
    tick();
    chk("irq_masked_on", {31'd0, Irq}, 32'h1);
    wr(B + 32'h08, 32'h1);
    rchk("w1c_clear", B + 32'h08, 32'h0);
    tick();
    chk("irq_off", {31'd0, Irq}, 32'h0);

    // Irq three edges after the input change
    PortIn = 8'h5A;
    tick(); tick(); tick();
    chk("irq_n2", {31'd0, Irq}, 32'h0);
    tick();
    chk("irq_n3", {31'd0, Irq}, 32'h1);
    wr(B + 32'h08, 32'h1);
    tick();

    // set beats same-cycle W1C
    PortIn = 8'h3C;
    tick(); tick();
    wr(B + 32'h08, 32'h1);
    rchk("set_wins", B + 32'h08, 32'h1);
    wr(B + 32'h08, 32'h1);
    rchk("clr_after", B + 32'h08, 32'h0);
    rchk("ctrl_rd", B + 32'h14, 32'h4);

`ifdef MMIO_TIMER_EN
    // auto-reload timer
    wr(B + 32'h10, 32'd4);
    rchk("cmp_rd", B + 32'h10, 32'd4);
    wr(B + 32'h14, 32'hB);
    rchk("cnt_e0", B + 32'h0C, 32'd0);
    tick();
    rchk("cnt_e1", B + 32'h0C, 32'd1);
    tick(); tick(); tick();
    rchk("cnt_e4", B + 32'h0C, 32'd4);
    rchk("exp_e4", B + 32'h08, 32'h0);
    tick();
    rchk("cnt_reload", B + 32'h0C, 32'd0);
    rchk("exp_e5", B + 32'h08, 32'h2);
    chk("tirq_e5", {31'd0, Irq}, 32'h0);
    tick();
    chk("tirq_e6", {31'd0, Irq}, 32'h1);
    rchk("cnt_e6", B + 32'h0C, 32'd1);

    // one-shot
    wr(B + 32'h14, 32'h0);
    wr(B + 32'h08, 32'h2);
    rchk("exp_clr", B + 32'h08, 32'h0);
    wr(B + 32'h10, 32'd3);
    wr(B + 32'h14, 32'h1);
    tick(); tick(); tick();
    rchk("os_cnt3", B + 32'h0C, 32'd3);
    tick();
    rchk("os_hold", B + 32'h0C, 32'd3);
    rchk("os_en_off", B + 32'h14, 32'h0);
    rchk("os_exp", B + 32'h08, 32'h2);
    tick();
    rchk("os_hold2", B + 32'h0C, 32'd3);
`else
    wr(B + 32'h10, 32'd5);
    rchk("notmr_cmp", B + 32'h10, 32'h0);
    rchk("notmr_cnt", B + 32'h0C, 32'h0);
    wr(B + 32'h14, 32'hF);
    rchk("notmr_ctrl", B + 32'h14, 32'h4);
    tick(); tick();
    rchk("notmr_stat", B + 32'h08, 32'h0);
`endif

    // mid-run reset, with a store in flight
    wr(B, 32'hCAFE_F00D);
    Address = B; WriteData = 32'h5555_AAAA; MemWrite = 1'b1;
    reset = 1'b0; #1;
    chk("mrst_portout", PortOut, 32'h0);
    chk("mrst_irq", {31'd0, Irq}, 32'h0);
    tick();
    MemWrite = 1'b0;
    chk("mrst_nostore", PortOut, 32'h0);
    rchk("mrst_pin", B + 32'h04, 32'h0);
    rchk("mrst_ctrl", B + 32'h14, 32'h0);
    rchk("mrst_status", B + 32'h08, 32'h0);
    rchk("mrst_cnt", B + 32'h0C, 32'h0);
    rchk("mrst_cmp", B + 32'h10, 32'h0);
    reset = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mmio_port_responder.md
# mmio_port_responder

Memory-mapped I/O responder on the processor's data-memory bus, answering MEM-stage loads and stores. Decodes a 32-byte window at BASE_ADDR. Inside it, provides an output port register, a synchronized input port with change detection, and an optional compare timer. The top level muxes `ReadData` between data RAM and this block using `Hit`, and drives the processor `PortOut` from this block.

## Interface
- `BASE_ADDR`, 32'hFFFF_0000: window base, 32-byte aligned.
- `IN_WIDTH`, 8: width of `PortIn`, zero-extended on read.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Address`  in  32  byte address from the EX/MEM ALU result.
- `WriteData`  in  32  store data (forwarded rt value).
- `MemWrite`  in  1  store strobe.
- `MemRead`  in  1  load strobe.
- `PortIn`  in  IN_WIDTH  asynchronous external input pins.
- `ReadData`  out  32  combinational load data.
- `Hit`  out  1  combinational; `Address` lies inside the window.
- `PortOut`  out  32  registered output port.
- `Irq`  out  1  registered; OR of status flags enabled by their masks.

## Operation
- Decode:
  - `Hit` = `Address[31:5] == BASE_ADDR[31:5]`.
  - Register offset = `Address[4:2]`; `Address[1:0]` ignored.
  - A store takes effect only when `MemWrite & Hit`.
- Offsets:
  - 0x00 PORT_OUT: RW, 32 bits.
  - 0x04 PORT_IN: RO, synchronized input zero-extended.
  - 0x08 STATUS: bit0 IN_CHG, bit1 TMR_EXP; write-1-to-clear.
  - 0x0C TMR_COUNT: RO.
  - 0x10 TMR_CMP: RW.
  - 0x14 CTRL: bit0 TMR_EN, bit1 AUTO_RELOAD, bit2 IN_CHG_MASK, bit3 TMR_EXP_MASK. Any write to CTRL also zeroes TMR_COUNT.
  - 0x18 and 0x1C read 0; stores ignored.
- Reads:
  - `ReadData` is the selected register when `MemRead & Hit`, else 0.
  - No side effects on read.
  - `MemRead` and `MemWrite` together: `ReadData` shows the pre-write value.
- Input path:
  - Two-flop synchronizer s1→s2, then history flop s3.
  - PORT_IN reads s2.
  - IN_CHG sets when s2 != s3.
- Timer, when TMR_EN = 1:
  - TMR_COUNT increments by 1 each cycle, 32-bit wrap.
  - When TMR_COUNT == TMR_CMP: TMR_EXP sets.
  - AUTO_RELOAD = 1: count returns to 0.
  - AUTO_RELOAD = 0: count holds and TMR_EN clears.
  - TMR_CMP = 0 with AUTO_RELOAD = 1: TMR_EXP sets every cycle.
- Boundary rules:
  - A flag set event and a W1C clear in the same cycle: set wins.
  - A CTRL write in the same cycle as a compare match: the CTRL write wins; count is zeroed; TMR_EXP still sets.
- `Irq` = `(IN_CHG & IN_CHG_MASK) | (TMR_EXP & TMR_EXP_MASK)`, registered one cycle after the flag.

## Timing
- Reset, asynchronous and low-active: PORT_OUT, TMR_COUNT, TMR_CMP, CTRL, STATUS, s1, s2, s3 and `Irq` all go to 0.
- `ReadData` and `Hit` are combinational. They are valid in the same cycle as `Address`, for MEM-stage single-cycle loads.
- Store latency: the register updates at the edge ending the MEM cycle.
  - A load to the same offset in the next cycle returns the new value.
  - `PortOut` changes at that same edge.
- Input latency:
  - A `PortIn` change before edge N is readable in PORT_IN after edge N+1.
  - IN_CHG is set after edge N+2.
  - `Irq` asserts after edge N+3.
- Timer: with CTRL written at edge E (TMR_EN = 1), count = k after edge E+k. TMR_EXP is set at the edge where count == TMR_CMP was observed.
- Reset asserted mid-operation aborts any in-flight store. No partial state survives.

## Configuration
- `MMIO_TIMER_EN` defined: timer registers, TMR_EXP and TMR_EXP_MASK are present.
- `MMIO_TIMER_EN` undefined:
  - Offsets 0x0C and 0x10 read 0 and ignore stores.
  - CTRL bits 0, 1 and 3 read 0.
  - STATUS bit1 reads 0.
  - No timer flops are synthesized.

## Structure
- Shared package `mmio_pkg`:
  - Offset constants `MMIO_OFF_PORT_OUT` … `MMIO_OFF_CTRL`.
  - STATUS and CTRL bit-index constants.
  - Default `BASE_ADDR`.
- Sub-module `input_synchronizer`: parameterized width, two flops plus history flop, `changed` output. It is reusable for future input ports.

## Test plan
- Reset: assert `reset` = 0 mid-run → all readable registers are 0, `PortOut` = 0, `Irq` = 0.
- Store 0xDEADBEEF to 0xFFFF0000 → `PortOut` = 0xDEADBEEF after the edge. Load the same address next cycle → 0xDEADBEEF. Store to 0xFFFF0040 → `Hit` = 0, no change.
- `PortIn` 0x00→0xA5 → PORT_IN reads 0xA5 after 2 edges, STATUS = 0x1 after 3 edges. Store 0x1 to STATUS → STATUS = 0x0.
- Same-cycle flag set and W1C: `PortIn` toggles so IN_CHG sets on the cycle of a store of 0x1 to STATUS → STATUS still reads 0x1.
- Timer: TMR_CMP = 4, CTRL = 0xB → TMR_EXP sets when count reaches 4, then count returns to 0. `Irq` = 1 one cycle later.
- Timer one-shot: CTRL = 0x1, TMR_CMP = 3 → count holds at 3 and TMR_EN reads 0. Without `MMIO_TIMER_EN`: load 0x10 → 0.
